// File: rtl/bcd_multidigit_display.sv
// N-digit cascaded BCD up/down counter with prescaled tick, parallel load and wrap pulse,
// driving a time-multiplexed common-segment 7-segment display (shared F bus, one-hot AN).
module bcd_multidigit_display #(
    parameter int DIGITS    = 4,
    parameter int COUNT_DIV = 50_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic [6:0]            F,
    output logic [DIGITS-1:0]     AN
);

    localparam int PW = $clog2(COUNT_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]       prescaler;
    logic                tick;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       scan_idx;
    logic [4*DIGITS-1:0] bcd_step;
    logic [4*DIGITS-1:0] load_clean;
    logic                wrap;
    logic                chain;
    logic [3:0]          digit;
    logic [3:0]          shown;

    assign tick = (prescaler == PRE_LAST);

    // Ripple the carry/borrow upward: a digit only moves when every lower digit wrapped.
    always_comb begin
        bcd_step = bcd;
        chain    = 1'b1;
        digit    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = bcd[4*i +: 4];
            if (chain) begin
                if (up) begin
                    if (digit == 4'd9) begin
                        bcd_step[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step[4*i +: 4] = digit + 4'd1;
                        chain              = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        bcd_step[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_step[4*i +: 4] = digit - 4'd1;
                        chain              = 1'b0;
                    end
                end
            end
        end
        wrap = chain;
    end

    always_comb begin
        load_clean = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            bcd       <= '0;
            carry     <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (load) begin
                prescaler <= '0;
                bcd       <= load_clean;
            end else begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick && en) begin
                    bcd   <= bcd_step;
                    carry <= wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Digit mux by comparison rather than a computed slice, so DIGITS=1 needs no special case.
    always_comb begin
        AN    = '0;
        shown = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                AN[i] = 1'b1;
                shown = bcd[4*i +: 4];
            end
        end
    end

    always_comb begin
        F = 7'h3F;
        case (shown)
            4'd0: F = 7'h3F;
            4'd1: F = 7'h06;
            4'd2: F = 7'h5B;
            4'd3: F = 7'h4F;
            4'd4: F = 7'h66;
            4'd5: F = 7'h6D;
            4'd6: F = 7'h7D;
            4'd7: F = 7'h07;
            4'd8: F = 7'h7F;
            4'd9: F = 7'h6F;
            default: F = 7'h3F;
        endcase
    end

endmodule

// File: tb/tb_bcd_multidigit_display.sv
// Directed bench for bcd_multidigit_display with DIGITS=2, COUNT_DIV=4, SCAN_DIV=2.
module tb_bcd_multidigit_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] bcd;
    logic       carry;
    logic [6:0] F;
    logic [1:0] AN;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_multidigit_display #(
        .DIGITS(2),
        .COUNT_DIV(4),
        .SCAN_DIV(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .up(up),
        .load(load),
        .load_val(load_val),
        .bcd(bcd),
        .carry(carry),
        .F(F),
        .AN(AN)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the scan position follows from this alone.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int k);
        to_bcd = {4'(k / 10), 4'(k % 10)};
    endfunction

    initial begin
        logic [1:0] exp_an;
        #2;
        check("reset_bcd", bcd, 8'h00);
        check("reset_carry", carry, 0);
        check("reset_an", AN, 2'b01);
        check("reset_f", F, 7'h3F);

        @(posedge clk); #1;
        reset = 1'b0; en = 1'b1; up = 1'b1;
        step(3);
        check("pre_first_tick", bcd, 8'h00);
        step(1);
        check("first_tick", bcd, 8'h01);
        check("first_tick_carry", carry, 0);
        for (int k = 2; k <= 100; k++) begin
            step(4);
            check("count_up", bcd, to_bcd(k % 100));
            check("count_up_carry", carry, (k == 100) ? 1 : 0);
        end
        step(1);
        check("carry_one_cycle", carry, 0);

        up = 1'b0;
        step(3);
        check("down_wrap", bcd, 8'h99);
        check("down_wrap_carry", carry, 1);
        step(1);
        check("down_carry_one_cycle", carry, 0);

        load = 1'b1; load_val = 8'h10;
        step(1);
        load = 1'b0;
        check("load_10", bcd, 8'h10);
        step(4);
        check("borrow_10_09", bcd, 8'h09);
        check("borrow_no_carry", carry, 0);

        step(3);
        load = 1'b1; load_val = 8'h4C; up = 1'b1;
        step(1);
        load = 1'b0;
        check("load_clamp_on_tick", bcd, 8'h40);
        check("load_clamp_carry", carry, 0);
        step(3);
        check("load_restarts_prescaler", bcd, 8'h40);
        step(1);
        check("count_after_load", bcd, 8'h41);

        en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step(4);
            check("en_low_hold", bcd, 8'h41);
            check("en_low_carry", carry, 0);
        end
        en = 1'b1;
        step(4);
        check("en_resume_phase", bcd, 8'h42);

        en = 1'b0; load = 1'b1; load_val = 8'h73;
        step(1);
        load = 1'b0;
        check("load_73", bcd, 8'h73);
        for (int s = 0; s < 6; s++) begin
            exp_an = (((cyc / 2) % 2) == 1) ? 2'b10 : 2'b01;
            check("scan_an", AN, exp_an);
            check("scan_f", F, (exp_an == 2'b01) ? 7'h4F : 7'h07);
            step(1);
        end

        load = 1'b1; load_val = 8'h57;
        step(1);
        load = 1'b0;
        check("load_57", bcd, 8'h57);
        #3 reset = 1'b1;
        #1;
        check("async_reset_bcd", bcd, 8'h00);
        check("async_reset_an", AN, 2'b01);
        check("async_reset_f", F, 7'h3F);
        check("async_reset_carry", carry, 0);
        step(2);
        check("held_reset_bcd", bcd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_multidigit_display.md
Name: bcd_multidigit_display

Overview:
- Parametrised successor to the single-digit 1 Hz BCD counter/7-segment top.
- Holds an N-digit cascaded BCD counter driven by an internal prescaler, with up/down counting, enable, synchronous parallel load and a wrap pulse.
- Drives a time-multiplexed common-segment 7-segment display: one shared segment bus plus one-hot digit enables.
- Sits directly below the board top; segment and anode pins connect straight to the display.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- COUNT_DIV, 50_000_000, clk cycles per count tick (>=2); 1 Hz at 50 MHz.
- SCAN_DIV, 50_000, clk cycles each digit stays selected (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable, sampled on tick cycles only.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit i is in bits [4i+3:4i].
- bcd  out  4*DIGITS  current count, same packing as load_val.
- carry  out  1  one-cycle pulse on wrap (up past all-9s, or down past all-0s).
- F  out  7  segments, active-high; F[0]=a … F[6]=g.
- AN  out  DIGITS  one-hot digit enable, active-high; AN[i] selects digit i.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - prescaler = 0, bcd = 0, carry = 0, scan index = 0, scan counter = 0
  - AN = 1 (digit 0 selected), F = 7'h3F (glyph "0").
- Prescaler:
  - counts 0..COUNT_DIV-1 and wraps.
  - tick is the cycle in which prescaler == COUNT_DIV-1.
  - ticks occur every COUNT_DIV cycles whether or not en is high.
- Priority each cycle: load > (tick & en) > hold.
- load = 1:
  - bcd <= load_val, prescaler <= 0, carry <= 0.
  - Any digit of load_val greater than 9 is stored as 0 and its neighbours are unaffected.
  - A tick in the same cycle is discarded.
- tick & en & up:
  - Cascaded increment: digit i increments when all lower digits are 9.
  - A digit at 9 that receives a carry-in becomes 0.
  - All digits 9 -> all 0, and carry = 1 for exactly that one cycle.
- tick & en & !up:
  - Cascaded decrement: digit i decrements when all lower digits are 0.
  - A digit at 0 that receives a borrow-in becomes 9.
  - All digits 0 -> all 9, and carry = 1 for one cycle.
- carry is registered: high in the cycle after the wrapping edge, 0 otherwise.
- bcd is registered: a new value is visible in the cycle after the tick or load edge.
- Direction change takes effect on the next tick; there is no glitch or skipped count.
- en low at a tick: bcd holds, no carry; the prescaler keeps running.
- Scan counter:
  - counts 0..SCAN_DIV-1.
  - On wrap, scan index advances 0,1,…,DIGITS-1,0 (modulo DIGITS).
  - Scan is free-running and independent of en/load.
- AN = one-hot of scan index (registered). F = 7-segment decode of bcd digit[scan index]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - F follows combinationally from the registered scan index and bcd, so F and AN change in the same cycle.
- DIGITS = 1: AN is constantly 1; scan logic is degenerate but legal.
- Reset asserted mid-tick or mid-scan returns everything to the reset state immediately, with no partial update.
- The block never presents non-BCD digit values on bcd.

Test Plan:
- DIGITS=2, COUNT_DIV=4: release reset, en=1, up=1 -> bcd increments every 4 cycles: 00,01,…,09,10; after 99 -> 00 with carry high for exactly 1 cycle.
- up=0 from 00 -> next tick gives 99 with carry pulse. Then from 10 -> 09, confirming borrow across digits.
- load_val=8'h4C with load=1 asserted on a tick cycle -> bcd=40 (C clamped to 0), no count that tick, next count 4 cycles later -> 41.
- en=0 for 3 ticks -> bcd constant, carry 0; re-assert en -> counting resumes on the next tick, with prescaler phase unchanged.
- SCAN_DIV=2, bcd=8'h73 -> AN sequence 01,01,10,10,… with F=4F while AN=01 and F=07 while AN=10.
- Assert reset asynchronously (between clk edges) while bcd=57 -> bcd=00, AN=01, F=3F, carry=0 before the next clk edge.
